// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared HyperBus transaction types and defaults
package hyperbus_pkg;

  // Default geometry; the transaction record below is sized by these.
  localparam int unsigned HB_BURST_WIDTH = 12;
  localparam int unsigned HB_NR_CS       = 2;
  localparam int unsigned HB_MAX_BURST   = 256;

  // One HyperBus transaction as seen on the splitter's in/out channels.
  typedef struct packed {
    logic [HB_NR_CS-1:0]       cs;
    logic                      write;
    logic [HB_BURST_WIDTH-1:0] burst;
    logic                      burst_type;
    logic                      address_space;
    logic [31:0]               address;
  } hb_trans_t;

endpackage

// File: rtl/hyperbus_trans_splitter.sv
// rtl/hyperbus_trans_splitter.sv - splits long linear bursts into MAX_BURST-word sub-transactions
module hyperbus_trans_splitter
  import hyperbus_pkg::*;
#(
  parameter int unsigned BURST_WIDTH = HB_BURST_WIDTH,
  parameter int unsigned NR_CS       = HB_NR_CS,
  parameter int unsigned MAX_BURST   = HB_MAX_BURST
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_address_i,
  input  logic [NR_CS-1:0]       in_cs_i,
  input  logic                   in_write_i,
  input  logic [BURST_WIDTH-1:0] in_burst_i,
  input  logic                   in_burst_type_i,
  input  logic                   in_address_space_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_address_o,
  output logic [NR_CS-1:0]       out_cs_o,
  output logic                   out_write_o,
  output logic [BURST_WIDTH-1:0] out_burst_o,
  output logic                   out_burst_type_o,
  output logic                   out_address_space_o,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  input  logic [15:0]            rx_data_i,
  input  logic                   rx_last_i,
  input  logic                   rx_error_i,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic [15:0]            rx_data_o,
  output logic                   rx_last_o,
  output logic                   rx_error_o,
  input  logic                   b_valid_i,
  input  logic                   b_last_i,
  input  logic                   b_error_i,
  output logic                   b_valid_o,
  output logic                   b_last_o,
  output logic                   b_error_o
);

  localparam int unsigned            LOG2_MAX  = $clog2(MAX_BURST);
  localparam logic [BURST_WIDTH-1:0] MAX_W     = BURST_WIDTH'(MAX_BURST);
  localparam logic [BURST_WIDTH-1:0] ONE_W     = BURST_WIDTH'(1);
  localparam logic [31:0]            ADDR_STEP = 32'(2 * MAX_BURST);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state;
  hb_trans_t              cur;        // sub-transaction currently offered downstream
  logic [BURST_WIDTH-1:0] remain;     // words still to issue after the current sub
  logic [BURST_WIDTH-1:0] total;      // number of sub-transactions for this request
  logic [BURST_WIDTH-1:0] done_cnt;   // sub-transaction completions seen so far
  logic                   err_sticky;

  logic                   active;
  logic                   rx_comp;
  logic                   comp;
  logic                   last_pending;
  logic                   split_req;
  logic [BURST_WIDTH-1:0] next_len;
  logic                   final_b;
  logic                   idle_b;

  // Completion detection and the split decision for an incoming request.
  always_comb begin
    active       = (state != IDLE);
    rx_comp      = rx_valid_i & rx_ready_i & rx_last_i;
    comp         = active & (cur.write ? b_valid_i : rx_comp);
    last_pending = ((done_cnt + ONE_W) == total);
    split_req    = in_burst_type_i & ~in_address_space_i & (in_burst_i > MAX_W);
    next_len     = (remain > MAX_W) ? MAX_W : remain;
    final_b      = active & cur.write & b_valid_i & last_pending;
    idle_b       = ~active & b_valid_i;
  end

  // Request latch, sub-transaction sequencing and completion accounting.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cur        <= '0;
      remain     <= '0;
      total      <= '0;
      done_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (comp) begin
        done_cnt <= done_cnt + ONE_W;
      end
      if (active & cur.write & b_valid_i & b_error_i) begin
        err_sticky <= 1'b1;
      end
      case (state)
        IDLE: begin
          done_cnt <= '0;
          if (in_valid_i) begin
            cur <= '{cs:            in_cs_i,
                     write:         in_write_i,
                     burst:         split_req ? MAX_W : in_burst_i,
                     burst_type:    in_burst_type_i,
                     address_space: in_address_space_i,
                     address:       in_address_i};
            remain <= split_req ? (in_burst_i - MAX_W) : '0;
            total  <= split_req ? (((in_burst_i - ONE_W) >> LOG2_MAX) + ONE_W) : ONE_W;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (out_ready_i) begin
            if (remain == '0) begin
              state <= WAIT;
            end else begin
              cur.address <= cur.address + ADDR_STEP;
              cur.burst   <= next_len;
              remain      <= remain - next_len;
            end
          end
        end
        WAIT: begin
          if (done_cnt == total) begin
            state      <= IDLE;
            done_cnt   <= '0;
            err_sticky <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshakes, sub-transaction fields, RX pass-through and merged write response.
  always_comb begin
    in_ready_o          = rst_ni & (state == IDLE);
    out_valid_o         = rst_ni & (state == ISSUE);
    out_address_o       = cur.address;
    out_cs_o            = cur.cs;
    out_write_o         = cur.write;
    out_burst_o         = cur.burst;
    out_burst_type_o    = cur.burst_type;
    out_address_space_o = cur.address_space;
    rx_valid_o          = rx_valid_i;
    rx_ready_o          = rx_ready_i;
    rx_data_o           = rx_data_i;
    rx_error_o          = rx_error_i;
    rx_last_o           = rx_last_i & (~active | (~cur.write & last_pending));
    b_valid_o           = rst_ni & (final_b | idle_b);
    b_last_o            = rst_ni & (final_b | (idle_b & b_last_i));
    b_error_o           = rst_ni & ((final_b & (err_sticky | b_error_i)) | (idle_b & b_error_i));
  end

endmodule

// File: tb/tb_hyperbus_trans_splitter.sv
// tb/tb_hyperbus_trans_splitter.sv - directed self-checking bench for hyperbus_trans_splitter
module tb_hyperbus_trans_splitter;

  localparam int BW   = 12;
  localparam int NCS  = 2;
  localparam int MAXB = 256;

  typedef struct {
    logic [31:0]   addr;
    logic [BW-1:0] burst;
  } sub_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           in_valid_i, in_ready_o;
  logic [31:0]    in_address_i;
  logic [NCS-1:0] in_cs_i;
  logic           in_write_i, in_burst_type_i, in_address_space_i;
  logic [BW-1:0]  in_burst_i;
  logic           out_valid_o, out_ready_i;
  logic [31:0]    out_address_o;
  logic [NCS-1:0] out_cs_o;
  logic           out_write_o, out_burst_type_o, out_address_space_o;
  logic [BW-1:0]  out_burst_o;
  logic           rx_valid_i, rx_ready_o, rx_last_i, rx_error_i;
  logic [15:0]    rx_data_i, rx_data_o;
  logic           rx_valid_o, rx_ready_i, rx_last_o, rx_error_o;
  logic           b_valid_i, b_last_i, b_error_i;
  logic           b_valid_o, b_last_o, b_error_o;

  hyperbus_trans_splitter #(.BURST_WIDTH(BW), .NR_CS(NCS), .MAX_BURST(MAXB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_address_i(in_address_i),
    .in_cs_i(in_cs_i), .in_write_i(in_write_i), .in_burst_i(in_burst_i),
    .in_burst_type_i(in_burst_type_i), .in_address_space_i(in_address_space_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_address_o(out_address_o),
    .out_cs_o(out_cs_o), .out_write_o(out_write_o), .out_burst_o(out_burst_o),
    .out_burst_type_o(out_burst_type_o), .out_address_space_o(out_address_space_o),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
    .rx_last_i(rx_last_i), .rx_error_i(rx_error_i),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
    .rx_last_o(rx_last_o), .rx_error_o(rx_error_o),
    .b_valid_i(b_valid_i), .b_last_i(b_last_i), .b_error_i(b_error_i),
    .b_valid_o(b_valid_o), .b_last_o(b_last_o), .b_error_o(b_error_o)
  );

  int tests = 0;
  int fails = 0;

  sub_t           exp_q[$];
  logic [31:0]    cur_addr;
  int             cur_burst;
  logic [NCS-1:0] cur_cs;
  logic           cur_write, cur_type, cur_space;
  logic           exp_b_valid, exp_b_last, exp_b_err, exp_rx_last;
  int             n_popped, b_pulses, rx_last_pulses;
  logic           held_v;
  logic [31:0]    held_addr;
  logic [BW-1:0]  held_burst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected sub-transaction list from the split rules.
  task automatic build(input logic wr, input logic btype, input logic space,
                       input logic [31:0] addr, input int burst, input logic [NCS-1:0] cs);
    int n;
    sub_t s;
    exp_q.delete();
    cur_addr = addr; cur_burst = burst; cur_cs = cs;
    cur_write = wr; cur_type = btype; cur_space = space;
    if (btype && !space && burst > MAXB) begin
      n = (burst + MAXB - 1) / MAXB;
      for (int i = 0; i < n; i++) begin
        s.addr  = addr + 32'(i * 2 * MAXB);
        s.burst = BW'((i == n - 1) ? (burst - i * MAXB) : MAXB);
        exp_q.push_back(s);
      end
    end else begin
      s.addr  = addr;
      s.burst = BW'(burst);
      exp_q.push_back(s);
    end
  endtask

  // Per-cycle compare of DUT outputs against model and driver expectations.
  always @(negedge clk) begin
    sub_t s;
    chk("b_valid_o", b_valid_o, exp_b_valid);
    chk("b_last_o", b_last_o, exp_b_last);
    chk("b_error_o", b_error_o, exp_b_err);
    chk("rx_last_o", rx_last_o, exp_rx_last);
    chk("rx_pass", {rx_valid_o, rx_ready_o, rx_error_o, rx_data_o},
        {rx_valid_i, rx_ready_i, rx_error_i, rx_data_i});
    if (rst_n && out_valid_o) begin
      if (held_v) begin
        chk("stall_addr", out_address_o, held_addr);
        chk("stall_burst", out_burst_o, held_burst);
      end
      if (out_ready_i) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_sub: got addr 0x%0h burst %0d expected none", out_address_o, out_burst_o);
        end else begin
          s = exp_q.pop_front();
          chk("sub_addr", out_address_o, s.addr);
          chk("sub_burst", out_burst_o, s.burst);
          chk("sub_fields", {out_cs_o, out_write_o, out_burst_type_o, out_address_space_o},
              {cur_cs, cur_write, cur_type, cur_space});
          n_popped++;
        end
      end
    end
    held_v     = rst_n && out_valid_o && !out_ready_i;
    held_addr  = out_address_o;
    held_burst = out_burst_o;
    if (b_valid_o) b_pulses++;
    if (rx_last_o && rx_valid_o) rx_last_pulses++;
  end

  task automatic clear_resp();
    b_valid_i = 0; b_last_i = 0; b_error_i = 0;
    rx_valid_i = 0; rx_last_i = 0; rx_error_i = 0;
    exp_b_valid = 0; exp_b_last = 0; exp_b_err = 0; exp_rx_last = 0;
  endtask

  // Present the modelled request and drain all sub-transactions.
  task automatic launch_and_issue(input bit stall);
    int n, guard, stall_cnt;
    n = exp_q.size();
    n_popped = 0; b_pulses = 0; rx_last_pulses = 0;
    @(posedge clk); #1;
    in_valid_i = 1; in_address_i = cur_addr; in_burst_i = BW'(cur_burst); in_cs_i = cur_cs;
    in_write_i = cur_write; in_burst_type_i = cur_type; in_address_space_i = cur_space;
    out_ready_i = 1;
    @(negedge clk);
    chk("in_ready_idle", in_ready_o, 1);
    @(posedge clk); #1;
    in_valid_i = 0;
    @(negedge clk);
    chk("out_valid_next", out_valid_o, 1);
    guard = 0; stall_cnt = 0;
    while (!(exp_q.size() == 0 && !out_valid_o) && guard < 200) begin
      @(posedge clk); #1;
      if (stall && n_popped >= 1 && stall_cnt < 5) begin
        out_ready_i = 0; stall_cnt++;
      end else begin
        out_ready_i = 1;
      end
      @(negedge clk);
      guard++;
    end
    chk("subs_left", exp_q.size(), 0);
    chk("out_valid_done", out_valid_o, 0);
    chk("subs_issued", n_popped, n);
    if (stall) chk("stall_cycles", stall_cnt, 5);
  endtask

  // Return one completion per sub (b or two rx beats) and check the WAIT exit timing.
  task automatic complete(input int n, input logic [7:0] err_mask);
    logic erracc;
    erracc = 0;
    for (int k = 0; k < n; k++) begin
      if (cur_write) begin
        @(posedge clk); #1;
        clear_resp();
        b_valid_i = 1; b_last_i = 1; b_error_i = err_mask[k];
        erracc = erracc | err_mask[k];
        exp_b_valid = (k == n - 1); exp_b_last = (k == n - 1);
        exp_b_err = (k == n - 1) & erracc;
      end else begin
        for (int j = 0; j < 2; j++) begin
          @(posedge clk); #1;
          clear_resp();
          rx_valid_i = 1; rx_last_i = (j == 1); rx_data_i = 16'($urandom);
          exp_rx_last = (j == 1) && (k == n - 1);
        end
      end
    end
    @(posedge clk); #1;
    clear_resp();
    @(negedge clk);
    chk("wait_hold", in_ready_o, 0);
    @(negedge clk);
    chk("wait_exit", in_ready_o, 1);
    chk("b_pulses", b_pulses, cur_write ? 1 : 0);
    chk("rx_last_pulses", rx_last_pulses, cur_write ? 0 : 1);
  endtask

  task automatic run(input bit stall, input logic [7:0] err_mask);
    int n;
    n = exp_q.size();
    launch_and_issue(stall);
    complete(n, err_mask);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; in_valid_i = 0; in_address_i = 0; in_burst_i = 0; in_cs_i = 0;
    in_write_i = 0; in_burst_type_i = 0; in_address_space_i = 0;
    out_ready_i = 1; rx_ready_i = 1; rx_data_i = 0;
    held_v = 0; n_popped = 0; b_pulses = 0; rx_last_pulses = 0;
    clear_resp();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_b", {b_valid_o, b_last_o, b_error_o}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", in_ready_o, 1);

    // Linear write 600 words, error on the second response
    build(1, 1, 0, 32'h0000_1000, 600, 2'b01);
    chk("model_n600", exp_q.size(), 3);
    chk("model_a1", exp_q[1].addr, 32'h0000_1200);
    chk("model_a2", exp_q[2].addr, 32'h0000_1400);
    chk("model_b2", exp_q[2].burst, 88);
    run(0, 8'b0000_0010);

    // Linear read, exactly MAX_BURST words
    build(0, 1, 0, 32'h0000_2000, 256, 2'b10);
    chk("model_n256", exp_q.size(), 1);
    run(0, 8'h00);

    // Wrapped read 600 words stays whole
    build(0, 0, 0, 32'h0000_3000, 600, 2'b01);
    chk("model_wrap_b", exp_q[0].burst, 600);
    run(0, 8'h00);

    // Linear read 513 words crossing the 4 GiB boundary
    build(0, 1, 0, 32'hFFFF_FE00, 513, 2'b11);
    chk("model_n513", exp_q.size(), 3);
    chk("model_wrap_a1", exp_q[1].addr, 32'h0000_0000);
    chk("model_wrap_a2", exp_q[2].addr, 32'h0000_0200);
    chk("model_last1", exp_q[2].burst, 1);
    run(0, 8'h00);

    // Linear write 1024 words with a 5-cycle downstream stall
    build(1, 1, 0, 32'h0000_8000, 1024, 2'b01);
    chk("model_n1024", exp_q.size(), 4);
    run(1, 8'h00);

    // Zero-length burst issued once
    build(0, 1, 0, 32'h0000_0040, 0, 2'b01);
    run(0, 8'h00);

    // Register-space write is never split
    build(1, 1, 1, 32'h0000_0100, 600, 2'b10);
    run(0, 8'h01);

    // Stray completions in IDLE pass straight through
    @(posedge clk); #1;
    b_valid_i = 1; b_last_i = 1; b_error_i = 1;
    rx_valid_i = 1; rx_last_i = 1; rx_data_i = 16'hBEEF;
    exp_b_valid = 1; exp_b_last = 1; exp_b_err = 1; exp_rx_last = 1;
    @(posedge clk); #1;
    clear_resp();
    @(negedge clk);
    chk("idle_ready", in_ready_o, 1);

    // Reset while waiting for write responses
    build(1, 1, 0, 32'h0000_4000, 300, 2'b01);
    launch_and_issue(0);
    @(posedge clk); #1;
    b_valid_i = 1; b_last_i = 1;
    @(posedge clk); #1;
    clear_resp();
    rst_n = 0; b_valid_i = 1; b_last_i = 1;
    @(negedge clk);
    chk("rst_wait_ready", in_ready_o, 0);
    chk("rst_wait_valid", out_valid_o, 0);
    @(posedge clk); #1;
    rst_n = 1; clear_resp();
    @(negedge clk);
    chk("rst_wait_idle", in_ready_o, 1);
    chk("rst_wait_no_b", b_pulses, 0);

    // Clean transaction after the abandoned one
    build(0, 1, 0, 32'h0000_5000, 300, 2'b10);
    run(0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hyperbus_trans_splitter.md
HYPERBUS_TRANS_SPLITTER -- requirements
Module: hyperbus_trans_splitter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BURST_WIDTH, 12, burst length field width, in 16-bit words.
- NR_CS, 2, chip-select width.
- MAX_BURST, 256, largest sub-transaction length in words; a power of two not exceeding 2^(BURST_WIDTH-1).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, synchronous and active-low.
- in_valid_i / in_ready_o  in/out  1  upstream transaction handshake.
- in_address_i  in  32  byte address.
- in_cs_i  in  NR_CS  chip select.
- in_write_i, in_burst_type_i, in_address_space_i  in  1 each  write flag; 1 = linear burst; 1 = register space.
- in_burst_i  in  BURST_WIDTH  length in words.
- out_valid_o / out_ready_i  out/in  1  downstream transaction handshake.
- out_address_o, out_cs_o, out_write_o, out_burst_o, out_burst_type_o, out_address_space_o  out  same widths as the in_* fields  sub-transaction fields.
- rx_valid_i / rx_ready_o, rx_data_i (16), rx_last_i, rx_error_i  in/out/in/in/in  read beats from the PHY side.
- rx_valid_o / rx_ready_i, rx_data_o (16), rx_last_o, rx_error_o  out/in/out/out/out  read beats to the AXI side.
- b_valid_i, b_last_i, b_error_i  in  1 each  per-sub-transaction write response.
- b_valid_o, b_last_o, b_error_o  out  1 each  merged write response.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE and WAIT.
REQ-004 in_ready_o SHALL be 1 only in IDLE; an in handshake SHALL latch all fields and move to ISSUE.
REQ-005 A transaction SHALL be split only if in_burst_type_i=1, in_address_space_i=0 and in_burst_i>MAX_BURST; otherwise it SHALL issue once, unmodified.
REQ-006 For split transactions, sub-transactions SHALL have burst MAX_BURST except the last, which carries the remainder (1..MAX_BURST).
REQ-007 Each sub-transaction's address SHALL be the previous address + 2*MAX_BURST, computed modulo 2^32 (wrap-around allowed).
REQ-008 out_valid_o SHALL be 1 throughout ISSUE; outputs SHALL hold stable while out_ready_i=0; each out handshake SHALL issue one sub-transaction.
REQ-009 After the last sub-transaction handshake, the FSM SHALL move to WAIT.
REQ-010 A completion counter SHALL count sub-transaction completions: b_valid_i for writes, rx_valid_i&rx_ready_i&rx_last_i for reads. Completions arriving in ISSUE SHALL be counted.
REQ-011 When completions equal the issued total and the FSM is in WAIT, the FSM SHALL return to IDLE on the next cycle.
REQ-012 RX path SHALL be combinational pass-through of valid, ready, data and error.
REQ-013 rx_last_o SHALL be rx_last_i AND (this is the final completion).
REQ-014 b_valid_o and b_last_o SHALL pulse for one cycle only on the final b_valid_i.
REQ-015 b_error_o SHALL be the OR of all b_error_i for the transaction, including the final one; the sticky error SHALL clear on entry to IDLE.
REQ-016 Zero latency from input to first output is not required: out_valid_o SHALL rise the cycle after the in handshake.
REQ-017 in_burst_i=0 SHALL be issued once with burst 0 and no split.
REQ-018 A completion that arrives in IDLE SHALL be passed through and SHALL NOT be counted.

Reset
REQ-019 On rst_ni=0 at a clk_i edge, the block SHALL enter IDLE and clear counters and the sticky error.
REQ-020 During reset, out_valid_o, b_valid_o, b_last_o and b_error_o SHALL be 0, and in_ready_o SHALL be 0.
REQ-021 A reset mid-transaction SHALL abandon it without emitting any further out or b pulses.

Structure
REQ-022 The transaction typedef (cs, write, burst, burst_type, address_space, address) SHALL live in the shared package hyperbus_pkg, along with the MAX_BURST default.
REQ-023 The block SHALL be one module with no sub-module; the RX path is wiring only.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Linear write, burst 600 @0x0000_1000 -> three subs: 256@0x1000, 256@0x1200, 88@0x1400; three b_valid_i, with error on the 2nd -> one b_valid_o with b_error_o=1.
- Linear read, burst 256 -> one sub, unmodified; rx_last_o equals rx_last_i.
- Wrapped read, burst 600 -> one sub with burst 600; one rx_last_o.
- Linear read, burst 513 @0xFFFF_FE00 -> subs @0xFFFF_FE00, @0x0000_0000, @0x0000_0200 (burst 1); rx_last_o only on the 3rd.
- out_ready_i held low for 5 cycles mid-split -> fields stable; no sub lost or duplicated.
- Reset asserted in WAIT -> IDLE next cycle, in_ready_o=1 once reset releases, no b_valid_o.
